// File: rtl/eh2_mem_bank_arb.sv
// Banked word memory with core/DMA per-bank arbitration, bounded DMA starvation
// and a zeroising init sequencer that runs after reset and on request.

module eh2_mem_bank_arb_bank #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 39,
  localparam int RW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [RW-1:0]    row,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] mem [DEPTH];

  // q only moves on a read so a captured word survives later init writes
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[row] <= wdata;
      else    q        <= mem[row];
    end
  end
endmodule

module eh2_mem_bank_arb_rtn #(
  parameter int NUM_BANKS = 4,
  parameter int WIDTH     = 39,
  parameter int RD_LAT    = 1,
  parameter int BB        = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rd_go,
  input  logic [BB-1:0]                   bank,
  input  logic [NUM_BANKS-1:0][WIDTH-1:0] bank_q,
  output logic                            rvalid,
  output logic [WIDTH-1:0]                rdata
);
  logic [RD_LAT:1]  vld_pipe;
  logic [BB-1:0]    bsel_q;
  logic [WIDTH-1:0] data, held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      bsel_q   <= '0;
    end else begin
      vld_pipe[1] <= rd_go;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (rd_go) bsel_q <= bank;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign data = bank_q[bsel_q];
  end else begin : g_lat2
    logic [WIDTH-1:0] d_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)              d_q <= '0;
      else if (vld_pipe[1]) d_q <= bank_q[bsel_q];
    end
    assign data = d_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         held <= '0;
    else if (rvalid) held <= data;
  end

  assign rvalid = vld_pipe[RD_LAT];
  assign rdata  = rvalid ? data : held;
endmodule

module eh2_mem_bank_arb #(
  parameter int NUM_BANKS  = 4,
  parameter int DEPTH      = 256,
  parameter int WIDTH      = 39,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 3,
  localparam int BB        = $clog2(NUM_BANKS),
  localparam int AW        = BB + $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_req,
  output logic             init_done,
  output logic             busy,
  input  logic             core_valid,
  output logic             core_ready,
  input  logic             core_we,
  input  logic [AW-1:0]    core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  output logic             core_rvalid,
  output logic [WIDTH-1:0] core_rdata,
  input  logic             dma_valid,
  output logic             dma_ready,
  input  logic             dma_we,
  input  logic [AW-1:0]    dma_addr,
  input  logic [WIDTH-1:0] dma_wdata,
  output logic             dma_rvalid,
  output logic [WIDTH-1:0] dma_rdata
);
  localparam int RW = $clog2(DEPTH);

  typedef enum logic {INIT, READY} state_t;
  state_t          state, state_n;
  logic [RW-1:0]   idx, idx_n;
  logic [3:0]      starve_cnt;

  logic [BB-1:0]   core_bank, dma_bank;
  logic            rdy_st, conflict, dma_pri, dma_lose;

  logic [NUM_BANKS-1:0]            b_en, b_we;
  logic [NUM_BANKS-1:0][RW-1:0]    b_row;
  logic [NUM_BANKS-1:0][WIDTH-1:0] b_wdata, b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      INIT: begin
        idx_n = idx + 1'b1;
        if (idx == RW'(DEPTH-1)) begin
          state_n = READY;
          idx_n   = '0;
        end
      end
      READY: if (init_req) state_n = INIT;
      default: state_n = INIT;
    endcase
  end

  assign busy      = (state == INIT);
  assign init_done = (state == INIT) && (idx == RW'(DEPTH-1));

  assign core_bank = core_addr[BB-1:0];
  assign dma_bank  = dma_addr[BB-1:0];
  assign rdy_st    = (state == READY);
  assign conflict  = core_valid && dma_valid && (core_bank == dma_bank);
  assign dma_pri   = (starve_cnt == 4'(STARVE_MAX));
  assign dma_lose  = rdy_st && conflict && !dma_pri;

  assign core_ready = rdy_st && core_valid && !(conflict && dma_pri);
  assign dma_ready  = rdy_st && dma_valid && !dma_lose;

  // Saturating count of consecutive lost conflicts; any DMA grant clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  starve_cnt <= '0;
    else if (dma_ready)                       starve_cnt <= '0;
    else if (dma_lose && !dma_pri)            starve_cnt <= starve_cnt + 1'b1;
  end

  always_comb begin
    b_en    = '0;
    b_we    = '0;
    b_row   = '0;
    b_wdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (state == INIT) begin
        b_en[b]  = 1'b1;
        b_we[b]  = 1'b1;
        b_row[b] = idx;
      end else if (core_ready && core_bank == BB'(b)) begin
        b_en[b]    = 1'b1;
        b_we[b]    = core_we;
        b_row[b]   = core_addr[AW-1:BB];
        b_wdata[b] = core_wdata;
      end else if (dma_ready && dma_bank == BB'(b)) begin
        b_en[b]    = 1'b1;
        b_we[b]    = dma_we;
        b_row[b]   = dma_addr[AW-1:BB];
        b_wdata[b] = dma_wdata;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    eh2_mem_bank_arb_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_bank (
      .clk(clk), .en(b_en[g]), .we(b_we[g]), .row(b_row[g]),
      .wdata(b_wdata[g]), .q(b_q[g])
    );
  end

  eh2_mem_bank_arb_rtn #(.NUM_BANKS(NUM_BANKS), .WIDTH(WIDTH), .RD_LAT(RD_LAT), .BB(BB)) u_core_rtn (
    .clk(clk), .rst(rst), .rd_go(core_ready && !core_we), .bank(core_bank),
    .bank_q(b_q), .rvalid(core_rvalid), .rdata(core_rdata)
  );

  eh2_mem_bank_arb_rtn #(.NUM_BANKS(NUM_BANKS), .WIDTH(WIDTH), .RD_LAT(RD_LAT), .BB(BB)) u_dma_rtn (
    .clk(clk), .rst(rst), .rd_go(dma_ready && !dma_we), .bank(dma_bank),
    .bank_q(b_q), .rvalid(dma_rvalid), .rdata(dma_rdata)
  );
endmodule
